// File: rtl/alu_route_sequencer.sv
// Sequences one ALU operation through the operand muxes and the writeback demux.
// All mux/demux controls are registered; req_ready is combinational from state and reset.
module alu_route_sequencer #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_src_a,
    input  logic [3:0]             req_src_b,
    input  logic [3:0]             req_dst,
    input  logic                   req_wb,
    output logic                   mux_a_enable,
    output logic [2:0]             mux_a_selector,
    output logic                   mux_b_enable,
    output logic [3:0]             mux_b_selector,
    output logic                   alu_start,
    output logic                   demux_enable,
    output logic [3:0]             demux_selector,
    output logic                   op_done,
    output logic                   err_illegal_src,
    output logic [COUNT_WIDTH-1:0] op_count
);

    typedef enum logic [1:0] {
        StIdle,
        StRoute,
        StExec,
        StWb
    } state_e;

    // ROUTE is the first of the ALU_LATENCY operand-hold cycles.
    localparam logic [3:0] CntLoad = 4'(ALU_LATENCY - 1);

    state_e                 state_q;
    logic [3:0]             cnt_q;
    logic [3:0]             dst_q;
    logic                   wb_q;
    logic                   mux_a_enable_q;
    logic [2:0]             mux_a_selector_q;
    logic                   mux_b_enable_q;
    logic [3:0]             mux_b_selector_q;
    logic                   alu_start_q;
    logic                   demux_enable_q;
    logic [3:0]             demux_selector_q;
    logic                   op_done_q;
    logic                   err_illegal_src_q;
    logic [COUNT_WIDTH-1:0] op_count_q;

    logic src_b_legal;

    assign src_b_legal = (req_src_b <= 4'd8);
    assign req_ready   = (state_q == StIdle) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            cnt_q             <= '0;
            dst_q             <= '0;
            wb_q              <= 1'b0;
            mux_a_enable_q    <= 1'b0;
            mux_a_selector_q  <= '0;
            mux_b_enable_q    <= 1'b0;
            mux_b_selector_q  <= '0;
            alu_start_q       <= 1'b0;
            demux_enable_q    <= 1'b0;
            demux_selector_q  <= '0;
            op_done_q         <= 1'b0;
            err_illegal_src_q <= 1'b0;
            op_count_q        <= '0;
        end else begin
            alu_start_q    <= 1'b0;
            op_done_q      <= 1'b0;
            demux_enable_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (src_b_legal) begin
                            mux_a_enable_q   <= 1'b1;
                            mux_a_selector_q <= req_src_a;
                            mux_b_enable_q   <= 1'b1;
                            mux_b_selector_q <= req_src_b;
                            alu_start_q      <= 1'b1;
                            dst_q            <= req_dst;
                            wb_q             <= req_wb;
                            cnt_q            <= CntLoad;
                            state_q          <= StRoute;
                        end else begin
                            // Illegal side-B source: flag it and remain ready.
                            err_illegal_src_q <= 1'b1;
                        end
                    end
                end

                StRoute, StExec: begin
                    if (cnt_q == 4'd0) begin
                        mux_a_enable_q   <= 1'b0;
                        mux_b_enable_q   <= 1'b0;
                        demux_selector_q <= dst_q;
                        demux_enable_q   <= wb_q && !dst_q[3];
                        op_done_q        <= 1'b1;
                        op_count_q       <= op_count_q + 1'b1;
                        state_q          <= StWb;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                        state_q <= StExec;
                    end
                end

                StWb: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mux_a_enable    = mux_a_enable_q;
    assign mux_a_selector  = mux_a_selector_q;
    assign mux_b_enable    = mux_b_enable_q;
    assign mux_b_selector  = mux_b_selector_q;
    assign alu_start       = alu_start_q;
    assign demux_enable    = demux_enable_q;
    assign demux_selector  = demux_selector_q;
    assign op_done         = op_done_q;
    assign err_illegal_src = err_illegal_src_q;
    assign op_count        = op_count_q;

endmodule
